// File: rtl/ptc_pkg.sv
// Shared widths, the packed readback code layout and the lock-tracker
// state encoding for the PTC code readback path.
package ptc_pkg;

   localparam int COARSE_W   = 4;
   localparam int FINE_W     = 3;
   localparam int COARSE_T_W = 16;
   localparam int FINE_T_W   = 8;
   localparam int Q_W        = COARSE_W + 2 * FINE_W;

   // Field order matches the SAR's Q: coarse in the MSBs, f2 in the LSBs.
   typedef struct packed {
      logic [COARSE_W-1:0] coarse;
      logic [FINE_W-1:0]   f1;
      logic [FINE_W-1:0]   f2;
   } code_t;

   typedef enum logic {
      ST_TRACK = 1'b0,
      ST_LOCK  = 1'b1
   } lock_st_e;

endpackage

// File: rtl/ptc_thermo_encoder.sv
// Combinational thermometer-to-binary encoder with integrity checks.
// A clean word is 0..01..1 with the MSB clear (code range 0..W-1).
module thermo_encoder #(
   parameter int W  = 8,
   parameter int CW = $clog2(W)
) (
   input  logic [W-1:0]  T,
   input  logic [W-1:0]  Tb,
   output logic [CW-1:0] code,
   output logic          bubble,
   output logic          cmp_err
);

   logic [CW:0] cnt;

   // Saturated popcount plus bubble / complement detection.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < W; i++) begin
         cnt = cnt + {{CW{1'b0}}, T[i]};
      end
      code = (cnt > (CW+1)'(W-1)) ? CW'(W-1) : cnt[CW-1:0];
      // T & (T+1) is zero only for a contiguous run of ones from bit 0;
      // the top bit set means the code exceeds the field range.
      bubble  = (|(T & (T + W'(1)))) | T[W-1];
      cmp_err = (T != ~Tb);
   end

endmodule

// File: rtl/ptc_code_readback.sv
// PTC code readback: samples the delay-line thermometer words, re-encodes
// them into the 10-bit SAR code, flags bubbles/complement errors and
// tracks lock stability.
// Optional macro DITHER_TOL_EN: a +/-1 step of the full code counts as
// equal for stability tracking.
module ptc_code_readback
   import ptc_pkg::*;
#(
   parameter int LOCK_CNT = 8,
   parameter int CNT_W    = 4
) (
   input  logic                  clk4,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [COARSE_T_W-1:0] T,
   input  logic [COARSE_T_W-1:0] Tb,
   input  logic [FINE_T_W-1:0]   T_f1,
   input  logic [FINE_T_W-1:0]   Tb_f1,
   input  logic [FINE_T_W-1:0]   T_f2,
   input  logic [FINE_T_W-1:0]   Tb_f2,
   output logic [Q_W-1:0]        Q_rb,
   output logic                  valid,
   output logic                  bubble,
   output logic                  cmp_err,
   output logic                  lock,
   output logic [CNT_W-1:0]      stable_cnt
);

   // Stage-1 sample registers
   logic [COARSE_T_W-1:0] t_q, tb_q;
   logic [FINE_T_W-1:0]   tf1_q, tbf1_q, tf2_q, tbf2_q;
   logic                  s1_vld_q;

   // Stage-2 output / tracker registers
   code_t           q_rb_q;
   logic            vld_q, bubble_q, cmp_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   lock_st_e        st_q, st_d;

   code_t code_s;
   logic  bub_c, bub_1, bub_2, cmp_c, cmp_1, cmp_2;
   logic  bubble_s, cmp_s, same_s, clr_s, load2_s;

   thermo_encoder #(.W(COARSE_T_W)) u_enc_c (
      .T(t_q), .Tb(tb_q), .code(code_s.coarse), .bubble(bub_c), .cmp_err(cmp_c)
   );
   thermo_encoder #(.W(FINE_T_W)) u_enc_f1 (
      .T(tf1_q), .Tb(tbf1_q), .code(code_s.f1), .bubble(bub_1), .cmp_err(cmp_1)
   );
   thermo_encoder #(.W(FINE_T_W)) u_enc_f2 (
      .T(tf2_q), .Tb(tbf2_q), .code(code_s.f2), .bubble(bub_2), .cmp_err(cmp_2)
   );

   assign bubble_s = bub_c | bub_1 | bub_2;
   assign cmp_s    = cmp_c | cmp_1 | cmp_2;
   // Stage 2 only loads real samples; an empty stage 1 would read as a
   // complement error.
   assign load2_s  = en & s1_vld_q;

`ifdef DITHER_TOL_EN
   logic [Q_W:0] new_x, old_x;
   assign new_x  = {1'b0, code_s};
   assign old_x  = {1'b0, q_rb_q};
   // Widened by one bit so 0 and 1023 are not treated as neighbours.
   assign same_s = (new_x == old_x) || (new_x == old_x + 1'b1) ||
                   (old_x == new_x + 1'b1);
`else
   assign same_s = (code_s == q_rb_q);
`endif

   assign clr_s = ~same_s | bubble_s | cmp_s;

   // Stage-1 capture of the raw control words.
   always_ff @(posedge clk4 or negedge rst_n) begin
      if (!rst_n) begin
         t_q      <= '0;
         tb_q     <= '0;
         tf1_q    <= '0;
         tbf1_q   <= '0;
         tf2_q    <= '0;
         tbf2_q   <= '0;
         s1_vld_q <= 1'b0;
      end else if (en) begin
         t_q      <= T;
         tb_q     <= Tb;
         tf1_q    <= T_f1;
         tbf1_q   <= Tb_f1;
         tf2_q    <= T_f2;
         tbf2_q   <= Tb_f2;
         s1_vld_q <= 1'b1;
      end
   end

   // Stage-2 output registers; valid pulses on every real load.
   always_ff @(posedge clk4 or negedge rst_n) begin
      if (!rst_n) begin
         q_rb_q   <= '0;
         bubble_q <= 1'b0;
         cmp_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         vld_q <= load2_s;
         if (load2_s) begin
            q_rb_q   <= code_s;
            bubble_q <= bubble_s;
            cmp_q    <= cmp_s;
         end
      end
   end

   // Lock tracker state register.
   always_ff @(posedge clk4 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         st_q  <= ST_TRACK;
      end else begin
         cnt_q <= cnt_d;
         st_q  <= st_d;
      end
   end

   // Lock tracker next state: count equal clean samples, clear on anything else.
   always_comb begin
      cnt_d = cnt_q;
      st_d  = st_q;
      if (load2_s) begin
         if (clr_s) begin
            cnt_d = '0;
            st_d  = ST_TRACK;
         end else begin
            if (cnt_q != CNT_W'(LOCK_CNT)) cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(LOCK_CNT)) st_d  = ST_LOCK;
         end
      end
   end

   assign Q_rb       = q_rb_q;
   assign valid      = vld_q;
   assign bubble     = bubble_q;
   assign cmp_err    = cmp_q;
   assign lock       = (st_q == ST_LOCK);
   assign stable_cnt = cnt_q;

endmodule

// File: tb/tb_ptc_code_readback.sv
module tb_ptc_code_readback;

   logic        clk4 = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [15:0] T = '0, Tb = '0;
   logic [7:0]  T_f1 = '0, Tb_f1 = '0, T_f2 = '0, Tb_f2 = '0;
   logic [9:0]  Q_rb;
   logic        valid, bubble, cmp_err, lock;
   logic [3:0]  stable_cnt;

   ptc_code_readback dut (
      .clk4(clk4), .rst_n(rst_n), .en(en),
      .T(T), .Tb(Tb), .T_f1(T_f1), .Tb_f1(Tb_f1), .T_f2(T_f2), .Tb_f2(Tb_f2),
      .Q_rb(Q_rb), .valid(valid), .bubble(bubble), .cmp_err(cmp_err),
      .lock(lock), .stable_cnt(stable_cnt)
   );

   always #5 clk4 = ~clk4;

   typedef struct {
      logic [9:0] q;
      logic       b, c;
      logic [3:0] cnt;
      logic       lk;
   } exp_t;

   exp_t exp_q[$];
   int n_chk = 0, n_pass = 0;

   // Directed vectors with hand-computed codes {coarse,f1,f2}
   logic [15:0] vT[7], vTb[7];
   logic [7:0]  vF1[7], vFb1[7], vF2[7], vFb2[7];
   logic [9:0]  vQ[7];
   logic        vB[7], vC[7];

   // Bench model: stage-1 occupancy and lock tracker
   int s1_idx = 0;
   bit s1_v = 0;
   int m_prev = 0, m_cnt = 0;
   bit m_lock = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   task automatic push_exp(input int i);
      exp_t e;
      bit eq;
      int q;
      q = int'(vQ[i]);
`ifdef DITHER_TOL_EN
      eq = (q == m_prev) || (q == m_prev + 1) || (q + 1 == m_prev);
`else
      eq = (q == m_prev);
`endif
      if (!eq || vB[i] || vC[i]) begin
         m_cnt = 0; m_lock = 0;
      end else begin
         if (m_cnt < 8) m_cnt++;
         if (m_cnt == 8) m_lock = 1;
      end
      m_prev = q;
      e.q = vQ[i]; e.b = vB[i]; e.c = vC[i]; e.cnt = 4'(m_cnt); e.lk = m_lock;
      exp_q.push_back(e);
   endtask

   // One clock of stimulus; the expectation for the stage-1 sample that
   // stage 2 will load at the next edge is queued now.
   task automatic step(input bit e, input int i);
      @(posedge clk4); #1;
      en = e;
      T = vT[i]; Tb = vTb[i]; T_f1 = vF1[i]; Tb_f1 = vFb1[i]; T_f2 = vF2[i]; Tb_f2 = vFb2[i];
      if (e) begin
         if (s1_v) push_exp(s1_idx);
         s1_idx = i; s1_v = 1;
      end
   endtask

   task automatic steps(input int n, input bit e, input int i);
      for (int k = 0; k < n; k++) step(e, i);
   endtask

   task automatic model_reset();
      exp_q.delete();
      s1_v = 0; m_prev = 0; m_cnt = 0; m_lock = 0;
   endtask

   // Monitor: every valid output is compared against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk4);
         if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(Q_rb), 32'h3FF);
            end else begin
               e = exp_q.pop_front();
               chk("q_rb", 32'(Q_rb), 32'(e.q));
               chk("flags", {30'd0, bubble, cmp_err}, {30'd0, e.b, e.c});
               chk("stable_cnt", 32'(stable_cnt), 32'(e.cnt));
               chk("lock", 32'(lock), 32'(e.lk));
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // V0: coarse 8, f1 3, f2 1
      vT[0]=16'h00FF; vTb[0]=16'hFF00; vF1[0]=8'h07; vFb1[0]=8'hF8; vF2[0]=8'h01; vFb2[0]=8'hFE;
      vQ[0]=10'b1000_011_001; vB[0]=0; vC[0]=0;
      // V1: f2 -> 2, one LSB above V0
      vT[1]=16'h00FF; vTb[1]=16'hFF00; vF1[1]=8'h07; vFb1[1]=8'hF8; vF2[1]=8'h03; vFb2[1]=8'hFC;
      vQ[1]=10'b1000_011_010; vB[1]=0; vC[1]=0;
      // V2: coarse bubble 00F7, popcount 7
      vT[2]=16'h00F7; vTb[2]=16'hFF08; vF1[2]=8'h07; vFb1[2]=8'hF8; vF2[2]=8'h01; vFb2[2]=8'hFE;
      vQ[2]=10'b0111_011_001; vB[2]=1; vC[2]=0;
      // V3: f1 complement mismatch
      vT[3]=16'h00FF; vTb[3]=16'hFF00; vF1[3]=8'h07; vFb1[3]=8'hF0; vF2[3]=8'h01; vFb2[3]=8'hFE;
      vQ[3]=10'b1000_011_001; vB[3]=0; vC[3]=1;
      // V4: coarse all ones -> MSB bubble, saturated to 15
      vT[4]=16'hFFFF; vTb[4]=16'h0000; vF1[4]=8'h07; vFb1[4]=8'hF8; vF2[4]=8'h01; vFb2[4]=8'hFE;
      vQ[4]=10'b1111_011_001; vB[4]=1; vC[4]=0;
      // V5: coarse bubble 0005 (count 2) plus f2 mismatch
      vT[5]=16'h0005; vTb[5]=16'hFFFA; vF1[5]=8'h07; vFb1[5]=8'hF8; vF2[5]=8'h01; vFb2[5]=8'h00;
      vQ[5]=10'b0010_011_001; vB[5]=1; vC[5]=1;
      // V6: all codes zero
      vT[6]=16'h0000; vTb[6]=16'hFFFF; vF1[6]=8'h00; vFb1[6]=8'hFF; vF2[6]=8'h00; vFb2[6]=8'hFF;
      vQ[6]=10'd0; vB[6]=0; vC[6]=0;

      repeat (3) @(posedge clk4);
      #2;
      chk("reset_outputs", {16'd0, Q_rb, valid, bubble, cmp_err, lock, stable_cnt},
          32'd0);
      rst_n = 1'b1;

      steps(12, 1, 0);           // settle, count up and lock
      step(1, 1);                // one-cycle f2 change
      steps(4, 1, 0);
      step(1, 2);                // coarse bubble
      steps(3, 1, 0);
      step(1, 3);                // f1 complement error
      steps(3, 1, 0);
      step(1, 4);                // saturated / MSB bubble
      step(1, 5);                // bubble and mismatch together
      steps(3, 1, 6);            // zero code
      steps(5, 1, 0);

      // Pause en for 3 cycles mid-count
      step(0, 0);
      step(0, 0);
      @(negedge clk4);
      chk("en_low_valid", 32'(valid), 32'd0);
      chk("en_low_cnt_frozen", 32'(stable_cnt), 32'(m_cnt));
      step(0, 0);
      @(negedge clk4);
      chk("en_low_cnt_frozen2", 32'(stable_cnt), 32'(m_cnt));
      steps(4, 1, 0);
      steps(2, 1, 0);

      // Asynchronous reset between edges while counting
      @(posedge clk4); #3;
      rst_n = 1'b0;
      en = 1'b0;
      #1;
      chk("async_reset_outputs", {16'd0, Q_rb, valid, bubble, cmp_err, lock, stable_cnt},
          32'd0);
      model_reset();
      #2;
      rst_n = 1'b1;
      steps(6, 1, 0);            // count restarts from 0
      steps(3, 0, 0);            // drain
      @(negedge clk4);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
